// File: rtl/seq_restoring_divider.sv
// -----------------------------------------------------------------------------
// seq_restoring_divider
//
// Unsigned sequential restoring divider. One trial subtraction per clock, one
// quotient bit per iteration, MSB first. A start/busy/done handshake frames
// each operation and the results hold until the next operation completes.
//
// Handshake: a request is accepted on a rising edge where i_start is high and
// the divider is in IDLE or DONE; i_start is ignored while o_busy is high.
// o_done is a one-cycle pulse in the cycle in which o_quotient, o_remainder
// and o_div_by_zero have just been updated. The operand inputs are only
// sampled on the accepting edge.
//
// Parameters
//   WIDTH          operand width in bits (>= 2)
//
// Ports
//   i_clk          rising-edge clock
//   i_rst          asynchronous active-high reset
//   i_start        request a divide
//   i_dividend     unsigned dividend, sampled with i_start
//   i_divisor      unsigned divisor, sampled with i_start
//   o_quotient     quotient of the last completed operation
//   o_remainder    remainder of the last completed operation
//   o_busy         high while iterating
//   o_done         one-cycle pulse, results valid/updated
//   o_div_by_zero  set with o_done when the divisor was 0, held with results
// -----------------------------------------------------------------------------
module seq_restoring_divider #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_by_zero
);

    // Counter must be able to hold the value WIDTH itself.
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    // The dividend register doubles as the quotient register: each iteration
    // shifts one dividend bit out of the top and one quotient bit in at the
    // bottom, so after WIDTH iterations it holds the full quotient.
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   trial_r;
    logic             no_borrow;
    logic [WIDTH-1:0] next_rem;
    logic [WIDTH-1:0] next_dvd;
    logic             last_iter;

    // One restoring iteration.
    // The partial remainder entering an iteration is always < divisor, so
    // trial_r < 2*divisor. The borrow decision therefore needs the full
    // WIDTH+1 bits, but when the subtraction is kept its result is < divisor
    // and fits in WIDTH bits, so a WIDTH-bit modular subtract is exact.
    always_comb begin
        trial_r   = {rem, dvd[WIDTH-1]};
        no_borrow = (trial_r >= {1'b0, dvs});
        if (no_borrow) begin
            next_rem = trial_r[WIDTH-1:0] - dvs;
        end else begin
            next_rem = trial_r[WIDTH-1:0];
        end
        next_dvd  = {dvd[WIDTH-2:0], no_borrow};
        last_iter = (cnt == CW'(1));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= S_IDLE;
            dvd           <= '0;
            dvs           <= '0;
            rem           <= '0;
            cnt           <= '0;
            o_quotient    <= '0;
            o_remainder   <= '0;
            o_div_by_zero <= 1'b0;
        end else begin
            case (state)
                // DONE accepts a new request exactly like IDLE, which allows
                // back-to-back operations without an idle gap.
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        dvd <= i_dividend;
                        dvs <= i_divisor;
                        rem <= '0;
                        cnt <= CW'(WIDTH);
                        if (i_divisor == '0) begin
                            // Division by zero finishes immediately with the
                            // conventional all-ones quotient.
                            state         <= S_DONE;
                            o_quotient    <= '1;
                            o_remainder   <= i_dividend;
                            o_div_by_zero <= 1'b1;
                        end else begin
                            state <= S_CALC;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end

                S_CALC: begin
                    rem <= next_rem;
                    dvd <= next_dvd;
                    cnt <= cnt - CW'(1);
                    if (last_iter) begin
                        state         <= S_DONE;
                        o_quotient    <= next_dvd;
                        o_remainder   <= next_rem;
                        o_div_by_zero <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Status outputs are pure decodes of the state register, so they drop
    // to 0 the instant reset is asserted.
    assign o_busy = (state == S_CALC);
    assign o_done = (state == S_DONE);

endmodule
